// File: rtl/usb_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// usb_rx_pkg : shared types and limits for the USB receive decoder
// Rev 1.0
// ----------------------------------------------------------------------------
package usb_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_SE0_A = 3'd2,
      ST_SE0_B = 3'd3,
      ST_ERR   = 3'd4
   } rx_state_t;

   // Encoded as {D+, D-}
   typedef enum logic [1:0] {
      LS_SE0 = 2'b00,
      LS_K   = 2'b01,
      LS_J   = 2'b10,
      LS_SE1 = 2'b11
   } line_state_t;

   localparam int unsigned STUFF_LIMIT = 6;
   localparam int unsigned IDLE_LIMIT  = 8;

   function automatic line_state_t classify(input logic dp, input logic dm);
      return line_state_t'({dp, dm});
   endfunction

endpackage
`default_nettype wire

// File: rtl/usb_line_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// usb_line_sync : two-flop synchronizer with configurable reset value
// Rev 1.0
// ----------------------------------------------------------------------------
module usb_line_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic n_rst,
   input  logic line_in,
   output logic line_sync
);

   logic r_meta;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_meta    <= RESET_VAL;
         line_sync <= RESET_VAL;
      end else begin
         r_meta    <= line_in;
         line_sync <= r_meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/decoder_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// decoder_rx : USB line receiver - NRZI decode, bit unstuffing, EOP detection
// Rev 1.0
// ----------------------------------------------------------------------------
module decoder_rx
   import usb_rx_pkg::*;
(
   input  logic clk,
   input  logic n_rst,
   input  logic d_plus,
   input  logic d_minus,
   input  logic shift_enable,
   output logic rx_bit,
   output logic rx_valid,
   output logic eop,
   output logic stuff_err,
   output logic rx_err,
   output logic busy,
   output logic d_edge
);

   logic        w_dp_sync, w_dm_sync;
   logic        r_dp_last, r_prev_dp;
   rx_state_t   r_state, w_state_nxt;
   logic [2:0]  r_ones, w_ones_nxt;
   logic [2:0]  r_jcnt, w_jcnt_nxt;
   logic        w_bit_nxt, w_valid_nxt, w_eop_nxt, w_serr_nxt, w_prev_nxt;
   line_state_t w_ls;
   logic        w_nrzi;

   usb_line_sync #(.RESET_VAL(1'b1)) u_sync_dp (
      .clk       (clk),
      .n_rst     (n_rst),
      .line_in   (d_plus),
      .line_sync (w_dp_sync)
   );

   usb_line_sync #(.RESET_VAL(1'b0)) u_sync_dm (
      .clk       (clk),
      .n_rst     (n_rst),
      .line_in   (d_minus),
      .line_sync (w_dm_sync)
   );

   assign w_ls   = classify(w_dp_sync, w_dm_sync);
   assign w_nrzi = (w_dp_sync == r_prev_dp);
   assign d_edge = w_dp_sync ^ r_dp_last;
   assign rx_err = (r_state == ST_ERR);
   assign busy   = (r_state != ST_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      w_ones_nxt  = r_ones;
      w_jcnt_nxt  = r_jcnt;
      w_bit_nxt   = rx_bit;
      w_valid_nxt = 1'b0;
      w_eop_nxt   = 1'b0;
      w_serr_nxt  = 1'b0;
      w_prev_nxt  = r_prev_dp;

      if (shift_enable) begin
         if (w_ls == LS_J || w_ls == LS_K) w_prev_nxt = w_dp_sync;
         if (w_ls == LS_SE0)               w_ones_nxt = 3'd0;

         case (r_state)
            ST_IDLE: begin
               if (w_ls == LS_K) begin
                  w_state_nxt = ST_RECV;
                  w_valid_nxt = 1'b1;
                  w_bit_nxt   = w_nrzi;
                  w_ones_nxt  = w_nrzi ? 3'd1 : 3'd0;
               end
            end
            ST_RECV: begin
               case (w_ls)
                  LS_J, LS_K: begin
                     // After STUFF_LIMIT ones this sample is a stuff slot, never data
                     if (r_ones == 3'(STUFF_LIMIT)) begin
                        w_ones_nxt = 3'd0;
                        if (w_nrzi) begin
                           w_serr_nxt  = 1'b1;
                           w_state_nxt = ST_ERR;
                        end
                     end else begin
                        w_valid_nxt = 1'b1;
                        w_bit_nxt   = w_nrzi;
                        w_ones_nxt  = w_nrzi ? r_ones + 3'd1 : 3'd0;
                     end
                  end
                  LS_SE0:  w_state_nxt = ST_SE0_A;
                  default: w_state_nxt = ST_ERR;
               endcase
            end
            ST_SE0_A: w_state_nxt = (w_ls == LS_SE0) ? ST_SE0_B : ST_ERR;
            ST_SE0_B: begin
               if (w_ls == LS_J) begin
                  w_state_nxt = ST_IDLE;
                  w_eop_nxt   = 1'b1;
               end else if (w_ls != LS_SE0) begin
                  w_state_nxt = ST_ERR;
               end
            end
            ST_ERR: begin
               if (w_ls != LS_J) begin
                  w_jcnt_nxt = 3'd0;
               end else if (r_jcnt == 3'(IDLE_LIMIT - 1)) begin
                  w_jcnt_nxt  = 3'd0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_jcnt_nxt = r_jcnt + 3'd1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase

         if (w_state_nxt == ST_IDLE) w_ones_nxt = 3'd0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= ST_IDLE;
         r_ones    <= 3'd0;
         r_jcnt    <= 3'd0;
         r_prev_dp <= 1'b1;
         r_dp_last <= 1'b1;
         rx_bit    <= 1'b1;
         rx_valid  <= 1'b0;
         eop       <= 1'b0;
         stuff_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ones    <= w_ones_nxt;
         r_jcnt    <= w_jcnt_nxt;
         r_prev_dp <= w_prev_nxt;
         r_dp_last <= w_dp_sync;
         rx_bit    <= w_bit_nxt;
         rx_valid  <= w_valid_nxt;
         eop       <= w_eop_nxt;
         stuff_err <= w_serr_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decoder_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_decoder_rx : packets built by a behavioural USB encoder, checked on decode
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_decoder_rx;

   logic clk = 1'b0;
   logic n_rst, d_plus, d_minus, shift_enable;
   logic rx_bit, rx_valid, eop, stuff_err, rx_err, busy, d_edge;

   decoder_rx dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .d_plus       (d_plus),
      .d_minus      (d_minus),
      .shift_enable (shift_enable),
      .rx_bit       (rx_bit),
      .rx_valid     (rx_valid),
      .eop          (eop),
      .stuff_err    (stuff_err),
      .rx_err       (rx_err),
      .busy         (busy),
      .d_edge       (d_edge)
   );

   always #5 clk = ~clk;

   // One line sample plus what the decoder must report for it
   typedef struct {
      logic dp;
      logic dm;
      logic v;
      logic b;
      logic e;
      logic s;
   } smp_t;

   smp_t q[$];
   logic lvl;
   int   ones;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   function automatic void push(input logic dp, input logic dm, input logic v,
                                input logic b, input logic e, input logic s);
      smp_t t;
      t = '{dp: dp, dm: dm, v: v, b: b, e: e, s: s};
      q.push_back(t);
   endfunction

   // NRZI encoder: a 0 toggles the line; a stuff 0 follows every six 1s
   function automatic void send_bit(input logic b, input logic stuffing);
      if (!b) lvl = ~lvl;
      if (ones == 6) begin
         push(lvl, ~lvl, 1'b0, 1'b0, 1'b0, b);
         ones = 0;
      end else begin
         push(lvl, ~lvl, 1'b1, b, 1'b0, 1'b0);
         ones = b ? ones + 1 : 0;
         if (stuffing && ones == 6) begin
            lvl = ~lvl;
            push(lvl, ~lvl, 1'b0, 1'b0, 1'b0, 1'b0);
            ones = 0;
         end
      end
   endfunction

   function automatic void start_packet();
      lvl  = 1'b1;
      ones = 0;
      for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
   endfunction

   function automatic void end_packet();
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      lvl  = 1'b1;
      ones = 0;
   endfunction

   function automatic void push_j(input int n);
      for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   task automatic do_sample(input smp_t s, input string tag);
      d_plus  = s.dp;
      d_minus = s.dm;
      @(negedge clk);
      chk({tag, ".quiet"}, rx_valid | eop | stuff_err, 1'b0);
      @(negedge clk);
      shift_enable = 1'b1;
      @(negedge clk);
      shift_enable = 1'b0;
      chk({tag, ".rx_valid"}, rx_valid, s.v);
      if (s.v) chk({tag, ".rx_bit"}, rx_bit, s.b);
      chk({tag, ".eop"}, eop, s.e);
      chk({tag, ".stuff_err"}, stuff_err, s.s);
   endtask

   task automatic play(input string tag);
      smp_t s;
      while (q.size() > 0) begin
         s = q.pop_front();
         do_sample(s, tag);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".rx_bit"},    rx_bit,    1'b1);
      chk({tag, ".rx_valid"},  rx_valid,  1'b0);
      chk({tag, ".eop"},       eop,       1'b0);
      chk({tag, ".stuff_err"}, stuff_err, 1'b0);
      chk({tag, ".rx_err"},    rx_err,    1'b0);
      chk({tag, ".busy"},      busy,      1'b0);
      chk({tag, ".d_edge"},    d_edge,    1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst        = 1'b0;
      d_plus       = 1'b1;
      d_minus      = 1'b0;
      shift_enable = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      n_rst = 1'b1;
      repeat (3) @(negedge clk);

      // Sync pattern only, then EOP
      start_packet();
      end_packet();
      play("sync_eop");
      chk("sync_eop.busy", busy, 1'b0);

      // Six data ones force a stuffed 0 that must be dropped
      start_packet();
      for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b1);
      end_packet();
      play("stuffed");
      chk("stuffed.busy", busy, 1'b0);

      // Randomized packets, biased toward 1s to exercise unstuffing
      for (int p = 0; p < 4; p++) begin
         start_packet();
         for (int i = 0; i < int'($urandom_range(8, 30)); i++)
            send_bit(($urandom % 4) != 0, 1'b1);
         end_packet();
         play("random");
         chk("random.busy", busy, 1'b0);
         chk("random.rx_err", rx_err, 1'b0);
      end

      // Seven consecutive ones without stuffing
      start_packet();
      for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
      play("stuff_viol");
      chk("stuff_viol.rx_err", rx_err, 1'b1);
      chk("stuff_viol.busy", busy, 1'b1);
      push_j(7);
      play("err_j7");
      chk("err_j7.rx_err", rx_err, 1'b1);
      push_j(1);
      play("err_j8");
      chk("err_j8.rx_err", rx_err, 1'b0);
      chk("err_j8.busy", busy, 1'b0);

      // Single-bit SE0 then K is illegal; a K inside the J run restarts recovery
      start_packet();
      for (int i = 0; i < 3; i++) send_bit(1'(($urandom % 2)), 1'b1);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      play("se0_k");
      chk("se0_k.rx_err", rx_err, 1'b1);
      push_j(4);
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push_j(7);
      play("err_restart");
      chk("err_restart.rx_err", rx_err, 1'b1);
      push_j(1);
      play("err_exit");
      chk("err_exit.rx_err", rx_err, 1'b0);

      // d_edge follows synchronized D+ with two cycles of latency
      for (int i = 0; i < 4; i++) begin
         d_plus = ~d_plus;
         @(negedge clk);
         chk("d_edge.early", d_edge, 1'b0);
         @(negedge clk);
         chk("d_edge.pulse", d_edge, 1'b1);
         chk("d_edge.no_valid", rx_valid, 1'b0);
         @(negedge clk);
         chk("d_edge.clear", d_edge, 1'b0);
      end
      repeat (2) @(negedge clk);

      // Reset mid-packet, immediately after a valid 0 bit
      start_packet();
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      play("pre_reset");
      chk("pre_reset.rx_valid", rx_valid, 1'b1);
      d_plus  = 1'b1;
      d_minus = 1'b0;
      n_rst   = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      @(negedge clk);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      start_packet();
      for (int i = 0; i < 10; i++) send_bit(1'(($urandom % 2)), 1'b1);
      end_packet();
      play("post_reset");
      chk("post_reset.busy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
